// File: rtl/io_input_port.sv
// io_input_port
//   Memory-mapped input peripheral on the data-memory bus. Push-buttons are
//   synchronized and debounced. Each accepted press is queued in a small FIFO
//   together with a snapshot of the slide switches. Software polls STATUS,
//   pops events through DATA, reads the live switches and drives CONTROL.
//
// Ports
//   CLK        system clock, rising edge
//   reset      asynchronous active-low reset
//   sel        peripheral selected for the current bus access
//   addr       word address (CPU address bits [6:2])
//   wdata      store data
//   mem_write  store strobe
//   mem_read   load strobe
//   rdata      registered load data, 1-cycle latency, held when not reading
//   key_n      push-buttons, active-low, asynchronous
//   sw         slide switches, asynchronous
//
// Bus handshake: there is no valid/ready pair. An access happens on every
// rising edge where sel is high together with mem_read or mem_write; the
// peripheral never stalls, and load data is in rdata one edge later.
//
// Register map (word address)
//   0 STATUS   [0] not_empty, [1] full, [2] overflow, [7:4] count
//   1 DATA     {12'b0, key_idx[1:0], sw_snapshot[17:0]} of the FIFO head, 0 if empty
//   2 SWITCH   synchronized switches, zero-extended
//   3 CONTROL  [0] enable; write: [1] flush FIFO, [2] clear overflow
module io_input_port #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int SW_WIDTH        = 18
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                sel,
    input  logic [4:0]          addr,
    input  logic [31:0]         wdata,
    input  logic                mem_write,
    input  logic                mem_read,
    output logic [31:0]         rdata,
    input  logic [3:0]          key_n,
    input  logic [SW_WIDTH-1:0] sw
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Synchronizers
    logic [3:0]          key_s1_q, key_s2_q;
    logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q;

    // Debounce
    logic [3:0]          key_acc_q, key_acc_d;
    logic [3:0][CW-1:0]  cnt_q, cnt_d;
    logic [3:0]          fall;
    logic                press_any;
    logic [1:0]          press_idx;

    // FIFO and control
    logic [19:0]         mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]       count_q;
    logic                ovf_q, ovf_d;
    logic                enable_q;
    logic                data_rd_prev_q;
    logic [31:0]         rdata_q;

    logic                not_empty, full;
    logic                rd_strobe, data_rd, pop_ok, ctrl_wr, flush;
    logic                push_req, push_ok, ovf_set;
    logic [19:0]         entry;
    logic [31:0]         rd_val;
    logic                unused_wdata;

    assign unused_wdata = ^wdata[31:3];
    assign rdata        = rdata_q;

    // A debounce counter runs only while the synchronized level disagrees
    // with the accepted level. A 1->0 acceptance is a press.
    always_comb begin
        key_acc_d = key_acc_q;
        cnt_d     = cnt_q;
        fall      = '0;
        for (int i = 0; i < 4; i++) begin
            if (key_s2_q[i] == key_acc_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                key_acc_d[i] = key_s2_q[i];
                cnt_d[i]     = '0;
                fall[i]      = key_acc_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Only the lowest-index press in a cycle is queued
    always_comb begin
        press_any = |fall;
        press_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (fall[i]) press_idx = 2'(i);
        end
    end

    assign not_empty = (count_q != '0);
    assign full      = (count_q == NW'(FIFO_DEPTH));
    assign rd_strobe = sel & mem_read;
    assign data_rd   = rd_strobe & (addr == 5'd1);
    // Pop only on the first cycle of a DATA read strobe
    assign pop_ok    = data_rd & ~data_rd_prev_q & not_empty;
    assign ctrl_wr   = sel & mem_write & (addr == 5'd3);
    assign flush     = ctrl_wr & wdata[1];
    assign push_req  = press_any & enable_q;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok   = push_req & (~full | pop_ok) & ~flush;
    assign ovf_set   = push_req & full & ~pop_ok & ~flush;
    assign entry     = {press_idx, 18'(sw_s2_q)};

    // Overflow set takes priority over the software clear
    always_comb begin
        ovf_d = ovf_q;
        if (ctrl_wr && wdata[2]) ovf_d = 1'b0;
        if (ovf_set)             ovf_d = 1'b1;
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            5'd0: rd_val = {24'b0, 4'(count_q), 1'b0, ovf_q, full, not_empty};
            5'd1: rd_val = not_empty ? {12'b0, mem_q[rd_ptr_q]} : 32'b0;
            5'd2: rd_val = 32'(sw_s2_q);
            5'd3: rd_val = {31'b0, enable_q};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            key_s1_q       <= 4'hF;
            key_s2_q       <= 4'hF;
            sw_s1_q        <= '0;
            sw_s2_q        <= '0;
            key_acc_q      <= 4'hF;
            cnt_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            ovf_q          <= 1'b0;
            enable_q       <= 1'b1;
            data_rd_prev_q <= 1'b0;
            rdata_q        <= '0;
        end else begin
            key_s1_q       <= key_n;
            key_s2_q       <= key_s1_q;
            sw_s1_q        <= sw;
            sw_s2_q        <= sw_s1_q;
            key_acc_q      <= key_acc_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            data_rd_prev_q <= data_rd;
            if (ctrl_wr) enable_q <= wdata[0];
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
                if (push_ok && !pop_ok)      count_q <= count_q + NW'(1);
                else if (!push_ok && pop_ok) count_q <= count_q - NW'(1);
            end
            // A held DATA strobe keeps showing the entry it popped
            if (rd_strobe && !(data_rd && data_rd_prev_q)) rdata_q <= rd_val;
        end
    end

    // Storage needs no reset; count and pointers define what is valid
    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= entry;
    end

endmodule

// File: doc/io_input_port.md
Name: io_input_port

Overview:
Memory-mapped input peripheral that answers CPU load/store accesses on the data-memory bus. It is the read-side counterpart of the hex-display output path.
- Synchronizes and debounces the board push-buttons.
- Queues each button press, together with a switch snapshot, in a small FIFO.
- Lets software poll status, pop events, read live switches and control the queue.
- Sits beside the data RAM; an upstream decoder drives `sel`.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a new key level (min 2)
FIFO_DEPTH, 4, event queue depth; power of two, 2..8
SW_WIDTH, 18, number of slide switches captured (max 18)

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
sel  input  1  peripheral selected for current bus access
addr  input  5  word address (CPU address bits [6:2])
wdata  input  32  store data
mem_write  input  1  store strobe
mem_read  input  1  load strobe
rdata  output  32  registered load data
key_n  input  4  push-buttons, active-low, asynchronous
sw  input  SW_WIDTH  slide switches, asynchronous

Behaviour:
- Reset (reset=0, async): rdata=0, FIFO empty, overflow=0, enable=1, accepted key levels=4'b1111, debounce counters=0, synchronizers=all 1 (key) / 0 (sw), read-strobe history=0.
- Input sync: 2-flop synchronizer on key_n and sw; all downstream logic uses synchronized values.
- Debounce, per key:
  - The counter increments while the synchronized level differs from the accepted level; it clears when the two match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, the accepted level takes the new value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Event generation:
  - An accepted 1->0 transition on key i is a press event {i[1:0], synchronized sw}, pushed only if enable=1.
  - Releases generate no event.
  - Simultaneous presses on several keys in one cycle: only the lowest index is pushed; the others are lost without setting overflow.
- FIFO:
  - Push when full: event discarded, overflow<=1 (sticky).
  - Push and pop in the same cycle: both occur, count unchanged. This also holds when full, and no overflow is set.
  - Pop when empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Register map (word addr), reads:
  - 0 STATUS: [0]=not_empty, [1]=full, [2]=overflow, [7:4]=count, rest 0.
  - 1 DATA: {12'b0, key_idx[1:0], sw_snapshot[17:0]} from FIFO head; unused sw bits 0; returns 0 if empty.
  - 2 SWITCH: synchronized sw zero-extended to 32 bits.
  - 3 CONTROL: [0]=enable, rest 0.
  - 4..31: return 0.
- Read timing:
  - On a rising edge where sel&mem_read=1, rdata<=selected register value; 1-cycle latency, same as data RAM.
  - rdata holds its value when not reading.
- Pop rule: a DATA read pops only on the first cycle of a sel&mem_read&(addr==1) assertion (edge-detected against the previous cycle). A strobe held for N cycles pops once, and rdata keeps showing the popped entry.
- Writes, on a rising edge with sel&mem_write=1:
  - addr 3: wdata[0]->enable; wdata[1]=1 flushes the FIFO; wdata[2]=1 clears overflow.
  - Flush and a push in the same cycle: flush wins and the event is dropped.
  - Overflow-clear and overflow-set in the same cycle: set wins.
  - Writes to other addresses are ignored.
- Read and write in the same cycle: both are processed. rdata reflects pre-write state.
- sel=0: no pop, no write, rdata unchanged.

Test Plan:
1. Reset, then read addrs 0..3 -> rdata 0x0, 0x0, sw value, 0x1. After reset deassert with key_n=1111: no events.
2. Bounce: pulse key_n[2] low for 5 cycles (DEBOUNCE_CYCLES=16) -> STATUS=0. Hold low 20 cycles with sw=0x155 -> STATUS=0x11. DATA read -> 0x00080155. Next STATUS read=0x0.
3. Press keys 0,1,2,3,0 sequentially (FIFO_DEPTH=4, each held and released >16 cycles) -> STATUS=0x47 (count 4, full, overflow, not_empty). Four DATA reads return key idx 0,1,2,3 in order. Write 0x4 to addr 3 -> STATUS=0x0.
4. Hold mem_read to addr 1 for 3 cycles with 2 queued events -> exactly one pop; rdata = first event for all 3 cycles; STATUS count=1.
5. Queue full, then a new press accepted on the same edge as a DATA-read pop -> count stays 4, overflow=0, newest entry at tail.
6. Write 0x2 (flush, enable=0) to addr 3, then press key 1 -> STATUS=0x0. Assert reset mid-debounce -> all outputs 0; the held key is re-accepted only after 16 stable cycles after release of reset and enable set to 1.
